// File: rtl/pong_pkg.sv
// pong_pkg: shared widths, FSM encoding and play-field bounds helper for the Pong frame driver
package pong_pkg;
   localparam int PLAY_SIZE = 64;
   localparam int POS_W     = 8;
   localparam int VEL_W     = 4;
   localparam int SCORE_W   = 4;
   typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, GAME_OVER} fsm_t;
   function automatic logic out_of_bounds(input logic [POS_W-1:0] pos);
      return ($signed(pos) < -PLAY_SIZE) || ($signed(pos) > PLAY_SIZE - 1);
   endfunction
endpackage

// File: rtl/pong_tick_gen.sv
// pong_tick_gen: free-running frame counter producing a one-cycle frame tick
module pong_tick_gen #(
   parameter int FRAME_DIV = 1000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_frame_tick
);
   localparam int CW = $clog2(FRAME_DIV);
   logic [CW-1:0] r_cnt;
   assign o_frame_tick = r_cnt == CW'(FRAME_DIV - 1);
   // count 0..FRAME_DIV-1 in every game state
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else r_cnt <= o_frame_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pong_frame_driver.sv
// pong_frame_driver: owns the Pong game state and sequences serve, play, scoring and game over
module pong_frame_driver
   import pong_pkg::*;
#(
   parameter int FRAME_DIV   = 1000000,
   parameter int SERVE_TICKS = 4,
   parameter int SERVE_VX    = 2,
   parameter int SERVE_VY    = 1,
   parameter int WIN_SCORE   = 9
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_pause,
   input  logic [1:0]   i_control_1,
   input  logic [1:0]   i_control_2,
   output logic [1:0]   o_cur_control_1,
   output logic [1:0]   o_cur_control_2,
   output logic [7:0]   o_cur_paddle_1_pos,
   output logic [7:0]   o_cur_paddle_2_pos,
   output logic [7:0]   o_cur_ball_pos_x,
   output logic [7:0]   o_cur_ball_pos_y,
   output logic [3:0]   o_cur_ball_vel_x,
   output logic [3:0]   o_cur_ball_vel_y,
   output logic [3:0]   o_cur_score_p1,
   output logic [3:0]   o_cur_score_p2,
   input  logic [7:0]   i_nxt_paddle_1_pos,
   input  logic [7:0]   i_nxt_paddle_2_pos,
   input  logic [7:0]   i_nxt_ball_pos_x,
   input  logic [7:0]   i_nxt_ball_pos_y,
   input  logic [3:0]   i_nxt_score_p1,
   input  logic [3:0]   i_nxt_score_p2,
   input  logic         i_nxt_bounce,
   output logic         o_frame_tick,
   output logic         o_game_over,
   output logic         o_winner,
   output logic [7:0]   o_bounce_count
);
   localparam int SW = $clog2(SERVE_TICKS + 1);
   fsm_t               r_state;
   logic [SW-1:0]      r_serve_cnt;
   logic               r_serve_dir;
   logic [1:0]         r_ctl_1, r_ctl_2;
   logic [POS_W-1:0]   r_pad_1, r_pad_2, r_bx, r_by;
   logic [VEL_W-1:0]   r_vx, r_vy;
   logic [SCORE_W-1:0] r_s1, r_s2;
   logic               r_winner;
   logic [7:0]         r_bounce;
   logic               w_tick, w_go;
   logic [VEL_W-1:0]   w_serve_vx, w_serve_vy;

   pong_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .o_frame_tick (w_tick)
   );

   assign w_go       = w_tick & ~i_pause;
   assign w_serve_vx = r_serve_dir ? VEL_W'(SERVE_VX) : -VEL_W'(SERVE_VX);
   assign w_serve_vy = VEL_W'(SERVE_VY);

   assign o_cur_control_1    = r_ctl_1;
   assign o_cur_control_2    = r_ctl_2;
   assign o_cur_paddle_1_pos = r_pad_1;
   assign o_cur_paddle_2_pos = r_pad_2;
   assign o_cur_ball_pos_x   = r_bx;
   assign o_cur_ball_pos_y   = r_by;
   assign o_cur_ball_vel_x   = r_vx;
   assign o_cur_ball_vel_y   = r_vy;
   assign o_cur_score_p1     = r_s1;
   assign o_cur_score_p2     = r_s2;
   assign o_frame_tick       = w_tick;
   assign o_game_over        = r_state == GAME_OVER;
   assign o_winner           = r_winner;
   assign o_bounce_count     = r_bounce;

   // game FSM and frame-captured state; entering SERVE always recentres the ball with serve velocity
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_serve_cnt <= '0;
         r_serve_dir <= 1'b0;
         r_ctl_1     <= '0;
         r_ctl_2     <= '0;
         r_pad_1     <= '0;
         r_pad_2     <= '0;
         r_bx        <= '0;
         r_by        <= '0;
         r_vx        <= '0;
         r_vy        <= '0;
         r_s1        <= '0;
         r_s2        <= '0;
         r_winner    <= 1'b0;
         r_bounce    <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_start) begin
               r_state     <= SERVE;
               r_serve_cnt <= '0;
               r_bx        <= '0;
               r_by        <= '0;
               r_vx        <= w_serve_vx;
               r_vy        <= w_serve_vy;
            end
            SERVE: if (w_go) begin
               r_serve_cnt <= r_serve_cnt + 1'b1;
               r_pad_1     <= i_nxt_paddle_1_pos;
               r_pad_2     <= i_nxt_paddle_2_pos;
               r_ctl_1     <= i_control_1;
               r_ctl_2     <= i_control_2;
               if (r_serve_cnt == SW'(SERVE_TICKS - 1)) r_state <= PLAY;
            end
            PLAY: if (w_go) begin
               r_pad_1  <= i_nxt_paddle_1_pos;
               r_pad_2  <= i_nxt_paddle_2_pos;
               r_ctl_1  <= i_control_1;
               r_ctl_2  <= i_control_2;
               r_bx     <= i_nxt_ball_pos_x;
               r_by     <= i_nxt_ball_pos_y;
               r_s1     <= i_nxt_score_p1;
               r_s2     <= i_nxt_score_p2;
               r_vx     <= out_of_bounds(r_bx) ? -r_vx : r_vx;
               r_vy     <= out_of_bounds(r_by) ? -r_vy : r_vy;
               r_bounce <= r_bounce + 8'(i_nxt_bounce);
               if (i_nxt_score_p1 != r_s1) begin
                  r_serve_dir <= 1'b1;
                  r_state     <= SCORED;
               end else if (i_nxt_score_p2 != r_s2) begin
                  r_serve_dir <= 1'b0;
                  r_state     <= SCORED;
               end
            end
            SCORED: if (r_s1 >= SCORE_W'(WIN_SCORE)) begin
               r_state  <= GAME_OVER;
               r_winner <= 1'b0;
            end else if (r_s2 >= SCORE_W'(WIN_SCORE)) begin
               r_state  <= GAME_OVER;
               r_winner <= 1'b1;
            end else begin
               r_state     <= SERVE;
               r_serve_cnt <= '0;
               r_bx        <= '0;
               r_by        <= '0;
               r_vx        <= w_serve_vx;
               r_vy        <= w_serve_vy;
            end
            GAME_OVER: if (i_start) begin
               r_state     <= SERVE;
               r_serve_cnt <= '0;
               r_s1        <= '0;
               r_s2        <= '0;
               r_bounce    <= '0;
               r_bx        <= '0;
               r_by        <= '0;
               r_vx        <= w_serve_vx;
               r_vy        <= w_serve_vy;
            end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_pong_frame_driver.sv
// tb_pong_frame_driver: randomized and table-driven check of the Pong frame driver against a rule model
module tb_pong_frame_driver;
   localparam int FD = 4, ST = 2, SVX = 2, SVY = 1, WIN = 3;
   localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_SCORED = 3, P_GO = 4;

   logic       clk = 1'b0, rst_n = 1'b1, i_start = 1'b0, i_pause = 1'b0, i_nxt_bounce = 1'b0;
   logic [1:0] i_control_1 = '0, i_control_2 = '0, o_ctl_1, o_ctl_2;
   logic [7:0] i_nxt_p1 = '0, i_nxt_p2 = '0, i_nxt_x = '0, i_nxt_y = '0;
   logic [3:0] i_nxt_s1 = '0, i_nxt_s2 = '0;
   logic [7:0] o_p1, o_p2, o_x, o_y, o_bc;
   logic [3:0] o_vx, o_vy, o_s1, o_s2;
   logic       o_frame_tick, o_game_over, o_winner;

   int n_chk = 0, n_err = 0;
   int m_cnt, m_phase, m_serve_n, m_dir, m_c1, m_c2, m_p1, m_p2;
   int m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_win, m_bc;

   typedef struct {int nx, ny, b, ex, ey, evx, evy, ebc;} vec_t;
   vec_t tbl [8];

   pong_frame_driver #(.FRAME_DIV(FD), .SERVE_TICKS(ST), .SERVE_VX(SVX), .SERVE_VY(SVY), .WIN_SCORE(WIN)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_pause(i_pause),
      .i_control_1(i_control_1), .i_control_2(i_control_2),
      .o_cur_control_1(o_ctl_1), .o_cur_control_2(o_ctl_2),
      .o_cur_paddle_1_pos(o_p1), .o_cur_paddle_2_pos(o_p2),
      .o_cur_ball_pos_x(o_x), .o_cur_ball_pos_y(o_y),
      .o_cur_ball_vel_x(o_vx), .o_cur_ball_vel_y(o_vy),
      .o_cur_score_p1(o_s1), .o_cur_score_p2(o_s2),
      .i_nxt_paddle_1_pos(i_nxt_p1), .i_nxt_paddle_2_pos(i_nxt_p2),
      .i_nxt_ball_pos_x(i_nxt_x), .i_nxt_ball_pos_y(i_nxt_y),
      .i_nxt_score_p1(i_nxt_s1), .i_nxt_score_p2(i_nxt_s2), .i_nxt_bounce(i_nxt_bounce),
      .o_frame_tick(o_frame_tick), .o_game_over(o_game_over), .o_winner(o_winner), .o_bounce_count(o_bc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wrap4(input int v);
      return ((v + 8) & 15) - 8;
   endfunction

   function automatic bit oob(input int v);
      return v < -64 || v > 63;
   endfunction

   function automatic logic [1:0] rnd_ctl();
      int r = $urandom_range(0, 2);
      return r == 0 ? 2'b11 : r == 1 ? 2'b00 : 2'b01;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_phase = P_IDLE; m_serve_n = 0; m_dir = 0; m_c1 = 0; m_c2 = 0; m_p1 = 0; m_p2 = 0;
      m_bx = 0; m_by = 0; m_vx = 0; m_vy = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_bc = 0;
   endtask

   task automatic serve_enter();
      m_phase = P_SERVE; m_serve_n = 0; m_bx = 0; m_by = 0;
      m_vx = m_dir ? SVX : -SVX; m_vy = SVY;
   endtask

   task automatic capture_pads();
      m_p1 = $signed(i_nxt_p1); m_p2 = $signed(i_nxt_p2);
      m_c1 = $signed(i_control_1); m_c2 = $signed(i_control_2);
   endtask

   // one clock edge of the game rules, using the inputs present before the edge
   task automatic model_edge();
      bit go = (m_cnt == FD - 1) && !i_pause;
      int ns1, ns2;
      m_cnt = (m_cnt + 1) % FD;
      case (m_phase)
         P_IDLE: if (i_start) serve_enter();
         P_SERVE: if (go) begin
            capture_pads();
            m_serve_n++;
            if (m_serve_n == ST) m_phase = P_PLAY;
         end
         P_PLAY: if (go) begin
            if (oob(m_bx)) m_vx = wrap4(-m_vx);
            if (oob(m_by)) m_vy = wrap4(-m_vy);
            capture_pads();
            m_bx = $signed(i_nxt_x); m_by = $signed(i_nxt_y);
            m_bc = (m_bc + int'(i_nxt_bounce)) % 256;
            ns1 = i_nxt_s1; ns2 = i_nxt_s2;
            if (ns1 != m_s1) begin m_dir = 1; m_phase = P_SCORED; end
            else if (ns2 != m_s2) begin m_dir = 0; m_phase = P_SCORED; end
            m_s1 = ns1; m_s2 = ns2;
         end
         P_SCORED: if (m_s1 >= WIN) begin m_phase = P_GO; m_win = 0; end
            else if (m_s2 >= WIN) begin m_phase = P_GO; m_win = 1; end
            else serve_enter();
         default: if (i_start) begin m_s1 = 0; m_s2 = 0; m_bc = 0; serve_enter(); end
      endcase
   endtask

   task automatic check_all();
      chk("frame_tick", int'(o_frame_tick), int'(m_cnt == FD - 1));
      chk("ctl1", $signed(o_ctl_1), m_c1);
      chk("ctl2", $signed(o_ctl_2), m_c2);
      chk("pad1", $signed(o_p1), m_p1);
      chk("pad2", $signed(o_p2), m_p2);
      chk("ball_x", $signed(o_x), m_bx);
      chk("ball_y", $signed(o_y), m_by);
      chk("vel_x", $signed(o_vx), m_vx);
      chk("vel_y", $signed(o_vy), m_vy);
      chk("score_p1", int'(o_s1), m_s1);
      chk("score_p2", int'(o_s2), m_s2);
      chk("game_over", int'(o_game_over), int'(m_phase == P_GO));
      chk("winner", int'(o_winner), m_win);
      chk("bounce_count", int'(o_bc), m_bc);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic tick_step();
      int n = 0;
      bit t;
      do begin
         t = (m_cnt == FD - 1);
         step();
         n++;
      end while (!t && n < 2 * FD);
      if (!t) begin
         n_chk++; n_err++;
         $display("FAIL tick_step: no frame tick within %0d cycles", n);
      end
   endtask

   task automatic wait_phase(input int target, input int budget);
      int n = 0;
      while (m_phase != target && n < budget) begin
         step();
         n++;
      end
      if (m_phase != target) begin
         n_chk++; n_err++;
         $display("FAIL wait_phase: phase %0d not reached, at %0d after %0d cycles", target, m_phase, n);
      end
   endtask

   initial begin
      tbl[0] = '{10, -5, 0, 10, -5, -2, 1, 0};
      tbl[1] = '{70, -5, 0, 70, -5, -2, 1, 0};
      tbl[2] = '{20, -5, 1, 20, -5, 2, 1, 1};
      tbl[3] = '{70, -70, 1, 70, -70, 2, 1, 2};
      tbl[4] = '{-65, 0, 0, -65, 0, -2, -1, 2};
      tbl[5] = '{5, 5, 0, 5, 5, 2, -1, 2};
      tbl[6] = '{63, -64, 0, 63, -64, 2, -1, 2};
      tbl[7] = '{0, 0, 0, 0, 0, 2, -1, 2};

      #1 rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all();
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("first_tick", int'(o_frame_tick), int'(i == 3));
      end

      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("idle_to_serve_ball_x", $signed(o_x), 0);
      wait_phase(P_PLAY, 3 * FD + 2);
      chk("play_vel_x", $signed(o_vx), -2);
      chk("play_vel_y", $signed(o_vy), 1);
      chk("play_ball_x", $signed(o_x), 0);

      for (int i = 0; i < 8; i++) begin
         i_nxt_x = 8'(tbl[i].nx);
         i_nxt_y = 8'(tbl[i].ny);
         i_nxt_bounce = 1'(tbl[i].b);
         i_nxt_p1 = 8'($urandom_range(0, 255));
         i_nxt_p2 = 8'($urandom_range(0, 255));
         i_control_1 = rnd_ctl();
         i_control_2 = rnd_ctl();
         tick_step();
         chk($sformatf("tbl%0d_x", i), $signed(o_x), tbl[i].ex);
         chk($sformatf("tbl%0d_y", i), $signed(o_y), tbl[i].ey);
         chk($sformatf("tbl%0d_vx", i), $signed(o_vx), tbl[i].evx);
         chk($sformatf("tbl%0d_vy", i), $signed(o_vy), tbl[i].evy);
         chk($sformatf("tbl%0d_bc", i), int'(o_bc), tbl[i].ebc);
      end
      i_nxt_bounce = 1'b0;

      i_nxt_s1 = 4'd1;
      tick_step();
      chk("p1_scored_value", int'(o_s1), 1);
      step();
      chk("p1_serve_vx", $signed(o_vx), 2);
      chk("p1_serve_x", $signed(o_x), 0);

      for (int k = 1; k <= 3; k++) begin
         wait_phase(P_PLAY, 3 * FD + 2);
         i_nxt_s2 = 4'(k);
         tick_step();
         step();
      end
      chk("go_flag", int'(o_game_over), 1);
      chk("go_winner", int'(o_winner), 1);
      for (int i = 0; i < 3 * FD; i++) begin
         i_nxt_x = 8'($urandom_range(0, 255));
         i_nxt_p1 = 8'($urandom_range(0, 255));
         i_nxt_s2 = 4'($urandom_range(0, 15));
         step();
      end
      chk("go_frozen_s2", int'(o_s2), 3);
      i_nxt_s1 = '0; i_nxt_s2 = '0;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("restart_s2", int'(o_s2), 0);
      chk("restart_go", int'(o_game_over), 0);

      wait_phase(P_PLAY, 3 * FD + 2);
      i_pause = 1'b1;
      i_nxt_x = 8'd33;
      i_nxt_s1 = 4'd5;
      for (int i = 0; i < 3 * FD; i++) step();
      chk("pause_hold_x", $signed(o_x), 0);
      chk("pause_hold_s1", int'(o_s1), 0);
      i_pause = 1'b0;
      i_nxt_s1 = 4'd0;

      for (int i = 0; i < 2500; i++) begin
         i_start = $urandom_range(0, 15) == 0;
         i_pause = $urandom_range(0, 7) == 0;
         i_control_1 = rnd_ctl();
         i_control_2 = rnd_ctl();
         i_nxt_p1 = 8'($urandom_range(0, 255));
         i_nxt_p2 = 8'($urandom_range(0, 255));
         i_nxt_x = 8'($urandom_range(0, 255));
         i_nxt_y = 8'($urandom_range(0, 255));
         i_nxt_bounce = 1'($urandom_range(0, 1));
         i_nxt_s1 = 4'(m_s1 + int'($urandom_range(0, 11) == 0));
         i_nxt_s2 = 4'(m_s2 + int'($urandom_range(0, 11) == 0));
         step();
      end
      i_start = 1'b0; i_pause = 1'b0;

      step();
      rst_n = 1'b0;
      #1 model_reset();
      check_all();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_start = i == 1;
         step();
      end
      i_start = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
